// File: rtl/tx_arb_pkg.sv
// tx_arb_pkg
// Shared types and constants for the TX arbiter slice.
//   tx_packet_t     : code presented to the TX packet encoder
//   HS_* codes      : encoding of the handshake responder's hs_type input
//   tx_arb_state_t  : arbiter sequencing states
//   tx_src_t        : which requester owns the packet currently in flight
//   *_DEFAULT       : default start timeout and inter-packet gap lengths
//   hs_code()       : maps hs_type to the packet code to send
package tx_arb_pkg;

   typedef enum logic [2:0] {
      NONE  = 3'b000,
      DATA  = 3'b001,
      ACK   = 3'b010,
      NAK   = 3'b011,
      STALL = 3'b100
   } tx_packet_t;

   localparam logic [1:0] HS_ACK   = 2'b00;
   localparam logic [1:0] HS_NAK   = 2'b01;
   localparam logic [1:0] HS_STALL = 2'b10;
   localparam logic [1:0] HS_RSVD  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_END,
      ST_GAP
   } tx_arb_state_t;

   typedef enum logic {
      SRC_HS,
      SRC_DATA
   } tx_src_t;

   localparam int unsigned START_TIMEOUT_DEFAULT = 32;
   localparam int unsigned IPG_CYCLES_DEFAULT    = 16;

   // Smallest FIFO occupancy accepted for a DATA packet when the
   // pre-issue occupancy check is built in.
   localparam logic [6:0] MIN_DATA_OCC = 7'd2;

   // The reserved handshake code is sent as STALL so the host never sees
   // an undefined PID.
   function automatic tx_packet_t hs_code(input logic [1:0] hs_type);
      tx_packet_t code;
      case (hs_type)
         HS_ACK:   code = ACK;
         HS_NAK:   code = NAK;
         HS_STALL: code = STALL;
         default:  code = STALL;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/tx_arb_timer.sv
// tx_arb_timer
// 8-bit loadable down-counter that saturates at zero. One instance is shared
// by the arbiter's start timeout and its inter-packet gap.
// Ports:
//   clk, n_rst     : clock, asynchronous active-low reset
//   load, load_val : load the counter (load wins over dec)
//   dec            : decrement by one, holding at zero
//   zero           : counter currently equals zero
module tx_arb_timer (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       load,
   input  logic [7:0] load_val,
   input  logic       dec,
   output logic       zero
);

   logic [7:0] count_q;
   logic [7:0] count_d;

   // Next count: a load overrides everything, otherwise step down and
   // stick at zero rather than wrapping to 255.
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (dec && (count_q != 8'd0)) begin
         count_d = count_q - 8'd1;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         count_q <= 8'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero = (count_q == 8'd0);

endmodule

// File: rtl/tx_arbiter.sv
// tx_arbiter
// Shares the TX packet encoder between the handshake responder (ACK/NAK/STALL)
// and the AHB data path (DATA). It presents the packet code, follows the
// encoder through TX_Transfer_Active/TX_Error, enforces a start timeout and an
// inter-packet gap, and returns exactly one done pulse per served request.
// Ports:
//   clk, n_rst                 : clock, asynchronous active-low reset
//   hs_req, hs_type            : handshake request level and type
//   data_req, buff_occ         : data request level and TX FIFO occupancy
//   TX_Transfer_Active         : encoder busy
//   TX_Error                   : encoder error pulse
//   TX_packet                  : packet code to the encoder (000 = none)
//   hs_done, data_done         : one-cycle completion pulses
//   xfer_err                   : failure flag, valid with a done pulse
//   tx_busy                    : arbiter is not idle
// Configuration:
//   TX_ARB_PRECHECK_EN : when defined, a data request with buff_occ < 2 is
//                        refused from IDLE with a data_done/xfer_err pulse
//                        instead of being sent to the encoder.
module tx_arbiter
   import tx_arb_pkg::*;
#(
   parameter int unsigned START_TIMEOUT = START_TIMEOUT_DEFAULT,
   parameter int unsigned IPG_CYCLES    = IPG_CYCLES_DEFAULT
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       hs_req,
   input  logic [1:0] hs_type,
   input  logic       data_req,
   input  logic [6:0] buff_occ,
   input  logic       TX_Transfer_Active,
   input  logic       TX_Error,
   output logic [2:0] TX_packet,
   output logic       hs_done,
   output logic       data_done,
   output logic       xfer_err,
   output logic       tx_busy
);

   // The timer's zero flag is examined before the edge that would take it
   // below zero, so loading N-1 makes the timeout/gap last exactly N cycles.
   localparam logic [7:0] START_LOAD = 8'(START_TIMEOUT - 1);
   localparam logic [7:0] IPG_LOAD   = 8'(IPG_CYCLES - 1);

   tx_arb_state_t state_q, state_d;
   tx_packet_t    pkt_q, pkt_d;
   tx_src_t       src_q, src_d;
   logic          err_flag_q, err_flag_d;
   logic          hs_done_q, hs_done_d;
   logic          data_done_q, data_done_d;
   logic          xfer_err_q, xfer_err_d;

   tx_packet_t    tx_pkt;
   logic          tmr_load;
   logic [7:0]    tmr_load_val;
   logic          tmr_dec;
   logic          tmr_zero;
   logic          data_reject;

`ifdef TX_ARB_PRECHECK_EN
   assign data_reject = (buff_occ < MIN_DATA_OCC);
`else
   logic unused_buff_occ;
   assign unused_buff_occ = ^buff_occ;
   assign data_reject     = 1'b0;
`endif

   tx_arb_timer u_timer (
      .clk      (clk),
      .n_rst    (n_rst),
      .load     (tmr_load),
      .load_val (tmr_load_val),
      .dec      (tmr_dec),
      .zero     (tmr_zero)
   );

   // Next-state, timer control, done pulses and the encoder code.
   always_comb begin
      state_d      = state_q;
      pkt_d        = pkt_q;
      src_d        = src_q;
      err_flag_d   = err_flag_q;
      hs_done_d    = 1'b0;
      data_done_d  = 1'b0;
      xfer_err_d   = 1'b0;
      tmr_load     = 1'b0;
      tmr_load_val = START_LOAD;
      tmr_dec      = 1'b0;
      tx_pkt       = NONE;

      case (state_q)
         ST_IDLE: begin
            if (hs_req) begin
               pkt_d        = hs_code(hs_type);
               src_d        = SRC_HS;
               err_flag_d   = 1'b0;
               tmr_load     = 1'b1;
               tmr_load_val = START_LOAD;
               state_d      = ST_ISSUE;
            end else if (data_req) begin
               if (data_reject) begin
                  data_done_d  = 1'b1;
                  xfer_err_d   = 1'b1;
                  tmr_load     = 1'b1;
                  tmr_load_val = IPG_LOAD;
                  state_d      = ST_GAP;
               end else begin
                  pkt_d        = DATA;
                  src_d        = SRC_DATA;
                  err_flag_d   = 1'b0;
                  tmr_load     = 1'b1;
                  tmr_load_val = START_LOAD;
                  state_d      = ST_ISSUE;
               end
            end
         end

         ST_ISSUE: begin
            tx_pkt  = pkt_q;
            tmr_dec = 1'b1;
            if (TX_Transfer_Active) begin
               state_d = ST_WAIT_END;
            end else if (tmr_zero) begin
               hs_done_d    = (src_q == SRC_HS);
               data_done_d  = (src_q == SRC_DATA);
               xfer_err_d   = 1'b1;
               tmr_load     = 1'b1;
               tmr_load_val = IPG_LOAD;
               state_d      = ST_GAP;
            end
         end

         ST_WAIT_END: begin
            // Masking with Active means the encoder sees 000 in the very
            // cycle it drops busy, so it cannot re-launch the same packet.
            tx_pkt = TX_Transfer_Active ? pkt_q : NONE;
            if (TX_Error) begin
               err_flag_d = 1'b1;
            end
            if (!TX_Transfer_Active) begin
               hs_done_d    = (src_q == SRC_HS);
               data_done_d  = (src_q == SRC_DATA);
               xfer_err_d   = err_flag_q | TX_Error;
               tmr_load     = 1'b1;
               tmr_load_val = IPG_LOAD;
               state_d      = ST_GAP;
            end
         end

         ST_GAP: begin
            tmr_dec = 1'b1;
            if (tmr_zero) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q     <= ST_IDLE;
         pkt_q       <= NONE;
         src_q       <= SRC_HS;
         err_flag_q  <= 1'b0;
         hs_done_q   <= 1'b0;
         data_done_q <= 1'b0;
         xfer_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         pkt_q       <= pkt_d;
         src_q       <= src_d;
         err_flag_q  <= err_flag_d;
         hs_done_q   <= hs_done_d;
         data_done_q <= data_done_d;
         xfer_err_q  <= xfer_err_d;
      end
   end

   assign TX_packet = tx_pkt;
   assign hs_done   = hs_done_q;
   assign data_done = data_done_q;
   assign xfer_err  = xfer_err_q;
   assign tx_busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter
// Directed bench for tx_arbiter. The stimulus thread pushes the expected
// packet issues and done pulses (code/kind, error flag, cycle number) into
// two queues; a monitor thread pops and compares them whenever the DUT starts
// a packet or pulses a done. Builds with or without TX_ARB_PRECHECK_EN.
module tb_tx_arbiter;

   localparam int ST_TO = 32;
   localparam int IPG   = 16;

   typedef struct {
      bit is_hs;
      bit err;
      int cyc;
   } done_exp_t;

   typedef struct {
      logic [2:0] code;
      int         cyc;
   } issue_exp_t;

   logic       clk;
   logic       n_rst;
   logic       hs_req;
   logic [1:0] hs_type;
   logic       data_req;
   logic [6:0] buff_occ;
   logic       tx_active;
   logic       tx_error;
   logic [2:0] TX_packet;
   logic       hs_done;
   logic       data_done;
   logic       xfer_err;
   logic       tx_busy;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   done_exp_t  done_sb[$];
   issue_exp_t issue_sb[$];

   tx_arbiter #(
      .START_TIMEOUT (ST_TO),
      .IPG_CYCLES    (IPG)
   ) dut (
      .clk                (clk),
      .n_rst              (n_rst),
      .hs_req             (hs_req),
      .hs_type            (hs_type),
      .data_req           (data_req),
      .buff_occ           (buff_occ),
      .TX_Transfer_Active (tx_active),
      .TX_Error           (tx_error),
      .TX_packet          (TX_packet),
      .hs_done            (hs_done),
      .data_done          (data_done),
      .xfer_err           (xfer_err),
      .tx_busy            (tx_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edge counter: after the k-th rising edge cyc == k.
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [2:0] actual, input logic [2:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic applyStimulus(input logic hs, input logic [1:0] hst, input logic dr, input logic [6:0] occ);
      hs_req   = hs;
      hs_type  = hst;
      data_req = dr;
      buff_occ = occ;
   endtask

   // Returns 2 ns after edge c, so anything driven now is sampled at edge c+1.
   task automatic wait_until(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic push_issue(input logic [2:0] code, input int c);
      issue_exp_t e;
      e.code = code;
      e.cyc  = c;
      issue_sb.push_back(e);
   endtask

   // Plays the encoder: Active rises in cycle issue+rise and stays high for
   // len cycles; TX_Error pulses in the err_off-th active cycle (none if < 0).
   task automatic encode(input int issue, input int rise, input int len, input int err_off,
                         input bit is_hs, input logic [2:0] code, output int done_cyc);
      done_exp_t e;
      done_cyc = issue + rise + len + 1;
      e.is_hs  = is_hs;
      e.err    = (err_off >= 0);
      e.cyc    = done_cyc;
      done_sb.push_back(e);
      wait_until(issue + rise);
      tx_active = 1'b1;
      for (int k = 0; k < len; k++) begin
         wait_until(issue + rise + k);
         tx_error = (k == err_off);
         if (k == len - 1) begin
            @(negedge clk);
            checkOutput("pkt_while_active", TX_packet, code);
         end
      end
      wait_until(issue + rise + len);
      tx_active = 1'b0;
      tx_error  = 1'b0;
   endtask

   // After a done in cycle d the arbiter must be back in IDLE at cycle d+IPG.
   task automatic settle(input int d);
      wait_until(d + IPG - 1);
      @(negedge clk);
      checkOutput("busy_in_gap_end", 3'(tx_busy), 3'd1);
      wait_until(d + IPG);
      @(negedge clk);
      checkOutput("idle_after_gap", 3'(tx_busy), 3'd0);
   endtask

   // Scoreboard monitor: compares each packet start and each done pulse
   // against the oldest expectation of its kind.
   initial begin
      logic [2:0] prev_pkt;
      done_exp_t  de;
      issue_exp_t ie;
      prev_pkt = 3'd0;
      forever begin
         @(negedge clk);
         if (n_rst === 1'b1) begin
            if (hs_done || data_done) begin
               checks++;
               if (done_sb.size() == 0) begin
                  errors++;
                  $display("[TB] FAIL done_unexpected: hs_done=%0b data_done=%0b xfer_err=%0b at cycle %0d, none expected",
                           hs_done, data_done, xfer_err, cyc);
               end else begin
                  de = done_sb.pop_front();
                  if (hs_done !== de.is_hs || data_done !== !de.is_hs ||
                      xfer_err !== de.err || cyc != de.cyc) begin
                     errors++;
                     $display("[TB] FAIL done_pulse: got hs=%0b data=%0b err=%0b cycle %0d, expected hs=%0b data=%0b err=%0b cycle %0d",
                              hs_done, data_done, xfer_err, cyc, de.is_hs, !de.is_hs, de.err, de.cyc);
                  end
               end
            end
            if (TX_packet != 3'd0 && prev_pkt == 3'd0) begin
               checks++;
               if (issue_sb.size() == 0) begin
                  errors++;
                  $display("[TB] FAIL issue_unexpected: TX_packet=%0h at cycle %0d, none expected", TX_packet, cyc);
               end else begin
                  ie = issue_sb.pop_front();
                  if (TX_packet !== ie.code || cyc != ie.cyc) begin
                     errors++;
                     $display("[TB] FAIL issue: got code %0h at cycle %0d, expected code %0h at cycle %0d",
                              TX_packet, cyc, ie.code, ie.cyc);
                  end
               end
            end
         end
         prev_pkt = TX_packet;
      end
   end

   initial begin
      int iss;
      int iss2;
      int d;
      int d2;
      int r;

      applyStimulus(1'b0, 2'b00, 1'b0, 7'd0);
      tx_active = 1'b0;
      tx_error  = 1'b0;
      n_rst     = 1'b1;
      #1 n_rst  = 1'b0;
      #1;
      checkOutput("rst_TX_packet", TX_packet, 3'd0);
      checkOutput("rst_hs_done", 3'(hs_done), 3'd0);
      checkOutput("rst_data_done", 3'(data_done), 3'd0);
      checkOutput("rst_xfer_err", 3'(xfer_err), 3'd0);
      checkOutput("rst_tx_busy", 3'(tx_busy), 3'd0);
      wait_until(3);
      n_rst = 1'b1;
      wait_until(cyc + 2);

      // NAK: Active 2 cycles after issue for 40 cycles, masked on the fall.
      $display("[TB] test: NAK handshake");
      applyStimulus(1'b1, 2'b01, 1'b0, 7'd0);
      iss = cyc + 1;
      push_issue(3'b011, iss);
      encode(iss, 2, 40, -1, 1'b1, 3'b011, d);
      @(negedge clk);
      checkOutput("nak_mask_on_fall", TX_packet, 3'd0);
      wait_until(d);
      applyStimulus(1'b0, 2'b00, 1'b0, 7'd0);
      settle(d);

      // Handshake and data together: ACK first, DATA IPG+1 cycles after hs_done.
      wait_until(cyc + 1);
      $display("[TB] test: simultaneous ACK and DATA");
      applyStimulus(1'b1, 2'b00, 1'b1, 7'd10);
      iss = cyc + 1;
      push_issue(3'b010, iss);
      encode(iss, 2, 3, -1, 1'b1, 3'b010, d);
      iss2 = d + IPG + 1;
      push_issue(3'b001, iss2);
      wait_until(d);
      applyStimulus(1'b0, 2'b00, 1'b1, 7'd10);
      wait_until(d + 3);
      @(negedge clk);
      checkOutput("gap_pkt_none", TX_packet, 3'd0);
      encode(iss2, 2, 3, -1, 1'b0, 3'b001, d2);
      wait_until(d2);
      applyStimulus(1'b0, 2'b00, 1'b0, 7'd10);
      settle(d2);

      // Start timeout: Active never rises.
      wait_until(cyc + 1);
      $display("[TB] test: start timeout");
      applyStimulus(1'b0, 2'b00, 1'b1, 7'd20);
      iss = cyc + 1;
      push_issue(3'b001, iss);
      d = iss + ST_TO;
      begin
         done_exp_t e;
         e.is_hs = 1'b0;
         e.err   = 1'b1;
         e.cyc   = d;
         done_sb.push_back(e);
      end
      wait_until(d - 1);
      @(negedge clk);
      checkOutput("timeout_last_issue", TX_packet, 3'b001);
      wait_until(d);
      applyStimulus(1'b0, 2'b00, 1'b0, 7'd20);
      @(negedge clk);
      checkOutput("timeout_gap_pkt", TX_packet, 3'd0);
      settle(d);

      // Low FIFO occupancy.
      wait_until(cyc + 1);
      $display("[TB] test: data with buff_occ=1");
      applyStimulus(1'b0, 2'b00, 1'b1, 7'd1);
`ifdef TX_ARB_PRECHECK_EN
      d = cyc + 1;
      begin
         done_exp_t e;
         e.is_hs = 1'b0;
         e.err   = 1'b1;
         e.cyc   = d;
         done_sb.push_back(e);
      end
      wait_until(d);
      applyStimulus(1'b0, 2'b00, 1'b0, 7'd1);
      @(negedge clk);
      checkOutput("precheck_pkt_none", TX_packet, 3'd0);
      checkOutput("precheck_busy", 3'(tx_busy), 3'd1);
      settle(d);
`else
      iss = cyc + 1;
      push_issue(3'b001, iss);
      encode(iss, 1, 10, 4, 1'b0, 3'b001, d);
      wait_until(d);
      applyStimulus(1'b0, 2'b00, 1'b0, 7'd1);
      settle(d);
`endif

      // Reserved handshake code goes out as STALL.
      wait_until(cyc + 1);
      $display("[TB] test: hs_type=11");
      applyStimulus(1'b1, 2'b11, 1'b0, 7'd0);
      iss = cyc + 1;
      push_issue(3'b100, iss);
      encode(iss, 3, 5, -1, 1'b1, 3'b100, d);
      wait_until(d);
      applyStimulus(1'b0, 2'b00, 1'b0, 7'd0);
      settle(d);

      // Reset during WAIT_END, request held and re-issued afterwards.
      wait_until(cyc + 1);
      $display("[TB] test: reset mid-packet");
      applyStimulus(1'b1, 2'b10, 1'b0, 7'd0);
      iss = cyc + 1;
      push_issue(3'b100, iss);
      wait_until(iss + 2);
      tx_active = 1'b1;
      wait_until(iss + 6);
      n_rst     = 1'b0;
      tx_active = 1'b0;
      #1;
      checkOutput("midrst_TX_packet", TX_packet, 3'd0);
      checkOutput("midrst_hs_done", 3'(hs_done), 3'd0);
      checkOutput("midrst_data_done", 3'(data_done), 3'd0);
      checkOutput("midrst_xfer_err", 3'(xfer_err), 3'd0);
      checkOutput("midrst_tx_busy", 3'(tx_busy), 3'd0);
      wait_until(cyc + 2);
      n_rst = 1'b1;
      r = cyc;
      push_issue(3'b100, r + 1);
      encode(r + 1, 2, 5, -1, 1'b1, 3'b100, d);
      wait_until(d);
      applyStimulus(1'b0, 2'b00, 1'b0, 7'd0);
      settle(d);

      wait_until(cyc + 2);
      while (done_sb.size() != 0) begin
         done_exp_t e;
         e = done_sb.pop_front();
         checks++;
         errors++;
         $display("[TB] FAIL done_missing: no done seen, expected hs=%0b err=%0b at cycle %0d", e.is_hs, e.err, e.cyc);
      end
      while (issue_sb.size() != 0) begin
         issue_exp_t e;
         e = issue_sb.pop_front();
         checks++;
         errors++;
         $display("[TB] FAIL issue_missing: no issue seen, expected code %0h at cycle %0d", e.code, e.cyc);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tx_arbiter.md
# tx_arbiter

Sequences and shares the TX packet encoder between the two sources that need it: the RX-side handshake responder (ACK/NAK/STALL) and the AHB-side data path (DATA packets from the FIFO). It drives the encoder's `TX_packet` code, tracks the packet through `TX_Transfer_Active`/`TX_Error`, enforces a start timeout and an inter-packet gap, and returns one completion pulse per request. It sits between the protocol/AHB control logic and the TX FSM.

## Interface
- `START_TIMEOUT`, 32: cycles allowed in ISSUE for `TX_Transfer_Active` to rise; range 2..255.
- `IPG_CYCLES`, 16: idle cycles in GAP after each packet before the next issue; range 1..255.
- `clk  in  1  system clock`
- `n_rst  in  1  reset, asynchronous, active-low`
- `hs_req  in  1  handshake request level, held until hs_done`
- `hs_type  in  2  00 ACK, 01 NAK, 10 STALL, 11 reserved (sent as STALL)`
- `data_req  in  1  data packet request level, held until data_done`
- `buff_occ  in  7  TX FIFO occupancy in bytes`
- `TX_Transfer_Active  in  1  encoder busy`
- `TX_Error  in  1  encoder error pulse`
- `TX_packet  out  3  000 none, 001 DATA, 010 ACK, 011 NAK, 100 STALL`
- `hs_done  out  1  one-cycle completion of a handshake request`
- `data_done  out  1  one-cycle completion of a data request`
- `xfer_err  out  1  valid with hs_done/data_done; 1 = failed`
- `tx_busy  out  1  high in every state except IDLE`

## Operation
- States: IDLE, ISSUE, WAIT_END, GAP.
- IDLE: `hs_req` has priority over `data_req`. On a request, latch the code into `pkt_reg` and the source into `src_reg`, load the timer with START_TIMEOUT, and go to ISSUE. A losing request stays pending, since requests are levels.
- ISSUE: `TX_packet = pkt_reg`; the timer decrements each cycle.
  - `TX_Transfer_Active`=1 → WAIT_END.
  - Timer reaches 0 first → done pulse with `xfer_err`=1, then GAP.
- WAIT_END: `TX_packet = TX_Transfer_Active ? pkt_reg : 000`, a combinational mask. This guarantees the encoder sees 000 in the same cycle it returns to its idle state, so the packet does not restart.
  - `TX_Error` sampled high sets a sticky `err_flag`.
  - `TX_Transfer_Active`=0 → done pulse for `src_reg` with `xfer_err=err_flag`; load the timer with IPG_CYCLES; go to GAP.
- GAP: `TX_packet`=000 and requests are ignored. Timer reaches 0 → IDLE.
- `err_flag` clears on entry to ISSUE.
- Simultaneous `hs_req` and `data_req` in IDLE: the handshake is served first. The data request is served after GAP if it is still asserted.
- A request that drops before the arbiter leaves IDLE is not served. Dropping a request after issue has no effect; the packet completes and the done pulse is still produced.
- Reset, including mid-packet, returns the block to IDLE with all outputs 0 and `pkt_reg`=000. Pending work is lost and requesters re-request.

## Timing
- Reset values: `TX_packet`=000, `hs_done`=0, `data_done`=0, `xfer_err`=0, `tx_busy`=0.
- A request sampled in IDLE at edge N gives state ISSUE and a valid `TX_packet` after edge N (latency 1).
- `hs_done`/`data_done`/`xfer_err` are registered:
  - They are high for exactly the one cycle after the edge at which `TX_Transfer_Active`=0 is sampled in WAIT_END.
  - On timeout, they are high for the one cycle after the edge at which the timer reaches 0.
- The next issue happens no earlier than IPG_CYCLES+1 cycles after a done pulse.
- The timer is 8 bits and never wraps: it saturates at 0.

## Configuration
- `TX_ARB_PRECHECK_EN` defined:
  - A data request with `buff_occ` < 2 is not issued.
  - The arbiter goes IDLE → GAP and pulses `data_done` with `xfer_err`=1 on the next cycle.
- `TX_ARB_PRECHECK_EN` undefined:
  - The data request is issued regardless of `buff_occ`.
  - The encoder's `TX_Error` is the only underflow report, reflected in `xfer_err`.

## Structure
- Package `tx_arb_pkg`:
  - `tx_packet_t` enum (NONE=0, DATA=1, ACK=2, NAK=3, STALL=4).
  - `hs_type` codes.
  - `tx_arb_state_t`.
  - Default START_TIMEOUT/IPG_CYCLES constants.
- One sub-module, `tx_arb_timer`: an 8-bit loadable, saturating down-counter with a `zero` flag. It is shared by the timeout and the gap.

## Test plan
- `hs_req`=1, `hs_type`=01; Active rises 2 cycles after issue and falls 40 cycles later → `TX_packet`=011, then 000 in the cycle Active falls; `hs_done`=1 for one cycle; `xfer_err`=0.
- `hs_req` and `data_req` asserted in the same cycle, `buff_occ`=10 → ACK/NAK/STALL issued first; DATA (001) issued exactly IPG_CYCLES+1 cycles after `hs_done`.
- `data_req`=1, Active never rises → `data_done`=1 and `xfer_err`=1 exactly START_TIMEOUT cycles after issue; `TX_packet`=000 in GAP.
- `data_req`, `buff_occ`=1:
  - With `TX_ARB_PRECHECK_EN` → `TX_packet` stays 000; `data_done`+`xfer_err` on the second cycle.
  - Without it → 001 issued; `TX_Error` pulse gives `xfer_err`=1.
- `hs_type`=11 → `TX_packet`=100.
- `n_rst` low mid-WAIT_END → all outputs 0 immediately; after release the block is in IDLE and a held request is re-issued.
